// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and load/store (D).
// D has priority; a streak counter forces an I grant after MAX_D_STREAK back-to-back D wins.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ack_o,
    output logic [31:0] i_data_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_data_q, i_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          grant_d_c;

    // D wins any contest unless I has already waited out a full streak
    always_comb begin
        grant_d_c = d_req_i & ~(i_req_i & (streak_q == SW'(MAX_D_STREAK)));
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_data_d    = i_data_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_i | d_req_i) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    owner_d   = grant_d_c;
                    if (grant_d_c) begin
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        if (i_req_i) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        i_ack_d  = 1'b1;
                        i_data_d = mem_rdata_i;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_data_q    <= i_data_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Stall is the only combinational output: it must track requests in the same cycle
    always_comb begin
        stall_o = ~rst_i & ((i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q));
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign i_ack_o     = i_ack_q;
    assign d_ack_o     = d_ack_q;
    assign i_data_o    = i_data_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported backing memory between the instruction-fetch path (I port) and the MEM-stage load/store path (D port) of the five-stage pipeline. It grants one requester at a time, runs a req/ack transaction on the memory side, and returns a one-cycle completion pulse with registered read data. It also drives the pipeline-wide stall that holds PC, IF_ID and the later stage registers while any access is outstanding. D has priority, and a streak limit prevents fetch starvation.

## Interface
- MAX_D_STREAK, default 4: consecutive D grants allowed while I waits before I is forced to win; range 1..15.
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- i_req_i  in  1  fetch request, held until i_ack_o
- i_addr_i  in  32  fetch byte address
- i_ack_o  out  1  one-cycle fetch completion pulse
- i_data_o  out  32  fetched instruction, valid when i_ack_o=1
- d_req_i  in  1  data request, held until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_ack_o  out  1  one-cycle data completion pulse (loads and stores)
- d_rdata_o  out  32  load data, valid when d_ack_o=1 for a load
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ack_i  in  1  one-cycle memory completion
- mem_rdata_i  in  32  memory read data, valid with mem_ack_i
- stall_o  out  1  pipeline stall

## Operation
- The block is a three-state FSM: IDLE, BUSY, RESP. A 1-bit owner register records the granted port (0=I, 1=D).
- **IDLE:**
  - If any request is asserted, grant it. The owner and the memory-side address, data and write enable are registered from the winner, and the FSM moves to BUSY.
  - Arbitration:
    - If only one port requests, it wins.
    - If both request, D wins unless streak == MAX_D_STREAK, in which case I wins.
- **Streak counter (4 bits):**
  - Increments on a D grant made while i_req_i=1.
  - Clears on any I grant.
  - Otherwise holds; it never exceeds MAX_D_STREAK.
- **BUSY:**
  - mem_req_o=1. The mem_* fields come from the grant registers, so they stay stable even if requester inputs change.
  - For an I grant, mem_we_o=0.
  - On mem_ack_i=1: capture mem_rdata_i into i_data_o (I) or d_rdata_o (D load), then go to RESP.
  - d_rdata_o is not updated on a store.
- **RESP:**
  - Pulse the owner's ack for exactly one cycle, then return to IDLE.
  - Request still high in the cycle after ack = new request.
- **Stall:** stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o). It is combinational and forced to 0 while rst_i=1.
- **Illegal or ignored inputs:**
  - mem_ack_i outside BUSY is ignored.
  - A requester dropping its req before ack is illegal. The granted transaction still completes and acks; stores are not cancelled.

## Timing
- **Reset values** (all asynchronous):
  - state=IDLE, owner=0, streak=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - i_ack_o=0, d_ack_o=0, i_data_o=0, d_rdata_o=0, stall_o=0.
- **Latency:**
  - A req seen in IDLE at cycle t gives mem_req_o=1 at t+1.
  - mem_ack_i at cycle m gives the requester ack at m+1.
  - Zero-wait memory (mem_ack_i in the first BUSY cycle) gives ack at t+2. The next grant can occur at t+3, so the minimum period is 3 cycles per access.
- **Simultaneous events:**
  - Both ports request in the same IDLE cycle: resolved by the priority and streak rules.
  - The losing port keeps stall_o high until its own ack.
- **Reset mid-transaction:** mem_req_o drops immediately, pending acks are lost, and requesters must reissue. The memory tolerates an abandoned request; a late mem_ack_i after reset is ignored.
- At most one of i_ack_o and d_ack_o is high in any cycle.

## Test plan
- **Single fetch:** i_req_i=1, addr 0x00000010, memory acks in the first BUSY cycle with 0x00A00093. Required: mem_req_o at t+1, i_ack_o=1 at t+2, i_data_o=0x00A00093, stall_o=1 in cycles t..t+1 and 0 at t+2.
- **Store then load, 3-cycle memory wait:**
  - Store 0xDEADBEEF to 0x20: mem_we_o=1, mem_wdata_o=0xDEADBEEF, d_ack_o 1 cycle after mem_ack_i, d_rdata_o unchanged.
  - Load from 0x20 returning 0xDEADBEEF: d_rdata_o=0xDEADBEEF.
- **Contention:** i_req_i and d_req_i rise in the same cycle. Required: D is served first, I is granted in the IDLE cycle after d_ack_o, and i_ack_o is never coincident with d_ack_o.
- **Starvation guard, MAX_D_STREAK=4:** d_req_i held continuously with i_req_i=1. Required: exactly 4 D grants, then an I grant, then streak=0 and D resumes.
- **Reset mid-BUSY:** assert rst_i during a D load. Required: mem_req_o=0 and all outputs 0 asynchronously. A mem_ack_i pulse after reset release produces no ack.
- **Address change while granted:** change i_addr_i during BUSY. Required: mem_addr_o holds the granted address until mem_ack_i.
